bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, multi-slave arbiter and sequencer for the shared system bus.
- Accepts bus requests from master 0 and master 1 and picks one owner by round-robin.
- Decodes the owner's target slave from the top address bits, waits for that slave to be ready, then holds the path until the owner finishes.
- Sits between the master ports and the slave-select/mux logic of the bus top.

Parameters:
- ADDR_W, 16, master address width.
- SID_W, 4, slave-ID field width; the ID is taken from addr[ADDR_W-1 -: SID_W].
- NUM_SLAVES, 3, number of implemented slaves; an ID >= NUM_SLAVES is invalid.
- TIMEOUT, 255, maximum cycles spent in WAIT_SLAVE before a nack.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m_req  in  2  bus request; bit i = master i; held until done.
- m_addr  in  2*ADDR_W  master addresses; bits [ADDR_W-1:0] = master 0.
- m_done  in  2  owner's end-of-transaction pulse.
- s_ready  in  NUM_SLAVES  slave i is free to accept a transaction.
- m_grant  out  2  one-hot or zero; the current owner.
- m_ack  out  2  1-cycle pulse: slave connected to the owner.
- m_nack  out  2  1-cycle pulse: invalid slave ID or timeout.
- s_sel  out  NUM_SLAVES  one-hot slave select; asserted only in BUSY.
- bus_busy  out  1  high in every state except IDLE.
- owner  out  1  index of the current or last owner.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE, prio=0, timeout counter=0.
  - All outputs are 0, including owner=0.
- All outputs are registered. State transitions occur on the rising edge of clk.
- IDLE:
  - If any m_req bit is set: winner = the only requester, or prio if both request.
  - Latch winner into owner and the winner's slave ID into sid.
  - m_grant[winner]=1 from the next cycle; go to DECODE.
- DECODE (1 cycle):
  - If sid >= NUM_SLAVES: pulse m_nack[owner] and go to RELEASE.
  - Otherwise clear the counter and go to WAIT_SLAVE.
- WAIT_SLAVE:
  - If s_ready[sid]=1: pulse m_ack[owner], set s_sel[sid]=1, go to BUSY.
  - Else if counter == TIMEOUT-1: pulse m_nack[owner] and go to RELEASE.
  - Otherwise increment the counter.
  - If the owner drops m_req while waiting: go to RELEASE with no ack or nack.
- BUSY:
  - Hold m_grant and s_sel.
  - On m_done[owner]=1, or m_req[owner]=0: go to RELEASE.
  - m_done from the non-owner is ignored.
- RELEASE (1 cycle):
  - m_grant=0 and s_sel=0.
  - prio = ~owner, so the other master wins the next tie.
  - Go to IDLE.
- Latency:
  - Request to grant: 1 cycle.
  - Grant to ack, with the slave already ready: 2 cycles (DECODE, then WAIT_SLAVE sees ready).
  - Done to grant drop: 1 cycle.
  - Minimum gap between consecutive grants: 2 cycles (RELEASE, IDLE).
- No preemption: a request from the non-owner never affects the current transaction.
- Simultaneous ack and owner dropping its request in WAIT_SLAVE: the request drop wins; no ack is pulsed.
- m_addr is sampled only in IDLE; later changes are ignored.
- Reset mid-transaction: all outputs clear immediately, the transaction is abandoned, and prio returns to 0.
- m_ack and m_nack are never high in the same cycle. At most one bit of m_grant is ever set.

Test Plan:
- Reset, then master 1 requests with addr 16'h10A8 and s_ready=3'b010.
  - m_grant=2'b10 one cycle later; m_ack[1] pulse 2 cycles after grant; s_sel=3'b010.
  - m_done[1] pulse → grants clear next cycle.
- Both masters request continuously, both addressing slave 0, each issuing m_done 4 cycles after its ack.
  - Grants alternate master 0, master 1, master 0, …; first owner=0.
  - Each grant gap is exactly 2 cycles.
- Master 0 requests with addr 16'h50A8 (ID 5 >= 3).
  - m_nack[0] pulses 1 cycle after grant; s_sel stays 0; bus_busy falls 2 cycles later.
- Master 0 requests slave 2 with s_ready=0 held.
  - m_nack[0] pulses after 255 cycles in WAIT_SLAVE; no m_ack; s_sel stays 0.
- Master 1 is in BUSY when rst is asserted mid-cycle.
  - All outputs are 0 asynchronously.
  - After release, with both masters requesting, master 0 wins.
- In WAIT_SLAVE, the owner drops m_req in the same cycle s_ready rises.
  - No m_ack; RELEASE then IDLE; s_sel never asserted.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_arbiter: two-master round-robin bus arbiter with slave decode,
// ready wait with timeout, and hold-until-done sequencing.
// Revision 1.0
// ----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int SID_W      = 4,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            m_req,
  input  logic [2*ADDR_W-1:0]   m_addr,
  input  logic [1:0]            m_done,
  input  logic [NUM_SLAVES-1:0] s_ready,
  output logic [1:0]            m_grant,
  output logic [1:0]            m_ack,
  output logic [1:0]            m_nack,
  output logic [NUM_SLAVES-1:0] s_sel,
  output logic                  bus_busy,
  output logic                  owner
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DECODE     = 3'd1,
    WAIT_SLAVE = 3'd2,
    BUSY       = 3'd3,
    RELEASE    = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_prio;
  logic [CNT_W-1:0]      r_cnt;
  logic [SID_W-1:0]      r_sid;

  logic                  w_winner;
  logic [ADDR_W-1:0]     w_win_addr;
  logic [NUM_SLAVES-1:0] w_sid_dec;
  logic                  w_sid_valid;
  logic                  w_ready;
  logic [1:0]            w_own_oh;
  logic                  w_own_req;
  logic                  w_own_done;
  logic                  w_unused_addr;

  assign w_winner   = (m_req == 2'b11) ? r_prio : m_req[1];
  assign w_win_addr = w_winner ? m_addr[2*ADDR_W-1 -: ADDR_W] : m_addr[ADDR_W-1:0];

  // An ID outside the implemented range decodes to all zeros, which is the invalid marker.
  generate
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_dec
      assign w_sid_dec[i] = (r_sid == SID_W'(i));
    end
  endgenerate

  assign w_sid_valid   = |w_sid_dec;
  assign w_ready       = |(w_sid_dec & s_ready);
  assign w_own_oh      = owner ? 2'b10 : 2'b01;
  assign w_own_req     = m_req[owner];
  assign w_own_done    = m_done[owner];
  assign w_unused_addr = ^w_win_addr[ADDR_W-SID_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_prio   <= 1'b0;
      r_cnt    <= '0;
      r_sid    <= '0;
      m_grant  <= '0;
      m_ack    <= '0;
      m_nack   <= '0;
      s_sel    <= '0;
      bus_busy <= 1'b0;
      owner    <= 1'b0;
    end else begin
      m_ack  <= '0;
      m_nack <= '0;
      case (r_state)
        IDLE: begin
          if (|m_req) begin
            owner    <= w_winner;
            r_sid    <= w_win_addr[ADDR_W-1 -: SID_W];
            m_grant  <= w_winner ? 2'b10 : 2'b01;
            bus_busy <= 1'b1;
            r_state  <= DECODE;
          end
        end
        DECODE: begin
          if (!w_sid_valid) begin
            m_nack  <= w_own_oh;
            m_grant <= '0;
            r_state <= RELEASE;
          end else begin
            r_cnt   <= '0;
            r_state <= WAIT_SLAVE;
          end
        end
        WAIT_SLAVE: begin
          // A dropped request outranks a same-cycle ready.
          if (!w_own_req) begin
            m_grant <= '0;
            r_state <= RELEASE;
          end else if (w_ready) begin
            m_ack   <= w_own_oh;
            s_sel   <= w_sid_dec;
            r_state <= BUSY;
          end else if (r_cnt == C_LAST) begin
            m_nack  <= w_own_oh;
            m_grant <= '0;
            r_state <= RELEASE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        BUSY: begin
          if (w_own_done || !w_own_req) begin
            m_grant <= '0;
            s_sel   <= '0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_prio   <= ~owner;
          bus_busy <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bus_arbiter: directed and randomized self-checking bench for bus_arbiter.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_req;
  logic [31:0] m_addr;
  logic [1:0]  m_done;
  logic [2:0]  s_ready;
  logic [1:0]  m_grant;
  logic [1:0]  m_ack;
  logic [1:0]  m_nack;
  logic [2:0]  s_sel;
  logic        bus_busy;
  logic        owner;

  int   total = 0;
  int   bad   = 0;
  logic prio_m = 1'b0;

  bus_arbiter #(.ADDR_W(16), .SID_W(4), .NUM_SLAVES(3), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_done(m_done),
    .s_ready(s_ready), .m_grant(m_grant), .m_ack(m_ack), .m_nack(m_nack),
    .s_sel(s_sel), .bus_busy(bus_busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"}, m_grant, 0);
    chk({tag, "_ack"}, m_ack, 0);
    chk({tag, "_nack"}, m_nack, 0);
    chk({tag, "_sel"}, s_sel, 0);
    chk({tag, "_busy"}, bus_busy, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1; m_req = '0; m_addr = '0; m_done = '0; s_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    prio_m = 1'b0;
  endtask

  function automatic logic [15:0] mk_addr();
    int n;
    logic [3:0] nib;
    n = $urandom_range(0, 4);
    nib = (n == 4) ? 4'($urandom_range(3, 15)) : 4'(n);
    return {nib, 12'($urandom)};
  endfunction

  // One complete transaction; expected owner and outcome come from the arbitration rules.
  task automatic txn(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                     input int d, input int hold);
    logic       own;
    logic [1:0] oh;
    int         sid;
    logic [2:0] sel;
    own = (req == 2'b11) ? prio_m : req[1];
    oh  = own ? 2'b10 : 2'b01;
    sid = own ? int'(a1[15:12]) : int'(a0[15:12]);
    m_req = req; m_addr = {a1, a0}; s_ready = '0; m_done = '0;
    tick();
    chk("grant", m_grant, oh);
    chk("owner", owner, own);
    chk("busy_on", bus_busy, 1);
    chk("decode_sel", s_sel, 0);
    m_addr = $urandom;
    if (sid >= 3) begin
      tick();
      chk("nack", m_nack, oh);
      chk("nack_ack", m_ack, 0);
      chk("nack_sel", s_sel, 0);
      chk("nack_grant", m_grant, 0);
    end else begin
      sel = 3'(1 << sid);
      for (int k = 0; k <= d; k++) begin
        s_ready = 3'($urandom) & ~sel;
        tick();
        chk("wait_ack", m_ack, 0);
        chk("wait_nack", m_nack, 0);
        chk("wait_grant", m_grant, oh);
      end
      s_ready = s_ready | sel;
      tick();
      chk("ack", m_ack, oh);
      chk("ack_sel", s_sel, sel);
      for (int k = 0; k < hold; k++) begin
        m_done = ~oh; s_ready = 3'($urandom);
        tick();
        chk("busy_grant", m_grant, oh);
        chk("busy_sel", s_sel, sel);
        chk("busy_ack", m_ack, 0);
      end
      m_done = oh;
      tick();
      chk("rel_grant", m_grant, 0);
      chk("rel_sel", s_sel, 0);
      chk("rel_busy", bus_busy, 1);
      m_done = '0;
    end
    m_req = '0;
    tick();
    chk("idle_busy", bus_busy, 0);
    chk("idle_owner", owner, own);
    prio_m = ~own;
  endtask

  initial begin
    int         n, ngr, low, done_at;
    logic       saw_ack, saw_sel, got, exp_own, prev;
    logic [1:0] cur_oh, rq;

    rst = 1'b1; m_req = '0; m_addr = '0; m_done = '0; s_ready = '0;
    apply_reset();

    // Master 1 to slave 1, slave already ready
    txn(2'b10, 16'h0000, 16'h10A8, 0, 0);

    // Both masters continuously requesting slave 0
    apply_reset();
    m_req = 2'b11; m_addr = {16'h0123, 16'h0ABC}; s_ready = 3'b001;
    exp_own = 1'b0; ngr = 0; low = 0; prev = 1'b0; done_at = -1; cur_oh = '0;
    for (int cyc = 0; cyc < 120 && ngr < 4; cyc++) begin
      tick();
      if (m_grant != 0 && !prev) begin
        cur_oh = exp_own ? 2'b10 : 2'b01;
        chk("alt_owner", m_grant, cur_oh);
        if (ngr > 0) chk("alt_gap", low, 2);
        ngr++;
        exp_own = ~exp_own;
      end
      low  = (m_grant == 0) ? low + 1 : 0;
      prev = (m_grant != 0);
      if (m_ack != 0) done_at = cyc + 4;
      m_done = (cyc == done_at) ? cur_oh : 2'b00;
    end
    chk("alt_count", ngr, 4);

    // Invalid slave ID
    apply_reset();
    txn(2'b01, 16'h50A8, 16'h0000, 0, 0);

    // Timeout with slave 2 never ready
    m_req = 2'b01; m_addr = {16'h0000, 16'h2ABC}; s_ready = '0;
    tick();
    chk("to_grant", m_grant, 2'b01);
    n = 0; got = 1'b0; saw_ack = 1'b0; saw_sel = 1'b0;
    while (!got && n < 400) begin
      tick();
      n++;
      if (m_ack != 0) saw_ack = 1'b1;
      if (s_sel != 0) saw_sel = 1'b1;
      if (m_nack != 0) got = 1'b1;
    end
    chk("to_nack_cycle", n, 256);
    chk("to_nack_val", m_nack, 2'b01);
    chk("to_no_ack", saw_ack, 0);
    chk("to_no_sel", saw_sel, 0);
    m_req = '0;
    tick();
    chk("to_idle_busy", bus_busy, 0);
    prio_m = 1'b1;

    // Asynchronous reset while master 1 is in BUSY
    m_req = 2'b10; m_addr = '0; s_ready = 3'b001;
    repeat (3) tick();
    chk("rstmid_ack", m_ack, 2'b10);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    m_req = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rstmid_prio", m_grant, 2'b01);
    apply_reset();

    // Owner drops its request as the slave becomes ready
    m_req = 2'b01; m_addr = {16'h0000, 16'h1000}; s_ready = '0;
    tick();
    chk("drop_grant", m_grant, 2'b01);
    tick();
    chk("drop_wait_ack", m_ack, 0);
    m_req = '0; s_ready = 3'b010;
    tick();
    chk("drop_ack", m_ack, 0);
    chk("drop_nack", m_nack, 0);
    chk("drop_sel", s_sel, 0);
    chk("drop_grant_off", m_grant, 0);
    chk("drop_busy_rel", bus_busy, 1);
    s_ready = '0;
    tick();
    chk("drop_busy_idle", bus_busy, 0);
    chk("drop_sel_idle", s_sel, 0);
    prio_m = 1'b1;

    // Randomized transactions against the transaction-level model
    for (int t = 0; t < 30; t++) begin
      rq = 2'($urandom_range(1, 3));
      txn(rq, mk_addr(), mk_addr(), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
